mc_control_unit: RTL and testbench

Multicycle control unit that consumes the 32-bit instruction word from the datapath's instruction output and sequences the datapath control strobes across FETCH/DECODE/EXEC/MEM/WB states. Sits directly downstream of the datapath's instruction output and drives its reg_write_en, reg_dst, alu_src, alu_ctrl, mem_write_en and mem_to_reg inputs. Also gates PC advance and waits on a data-memory ready handshake.

---
 rtl/mc_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multicycle control unit. It sequences FETCH/DECODE/EXEC/MEM/WB for a small
// MIPS-like subset (add, sub, and, or, slt, addi, lw, sw) and drives the
// datapath control strobes.
//
// Optional feature: define MC_CTRL_PERF_EN to build the instr_count and
// cycle_count performance counters. When it is undefined, both outputs are
// tied to zero and retired is still generated.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   instr[31:0]     instruction word, captured into IR only in FETCH
//   mem_ready       data-memory handshake, MEM holds while it is low
//   pc_en           PC advance strobe (FETCH)
//   reg_write_en    register file write (WB)
//   reg_dst         1 = rd, 0 = rt
//   alu_src         1 = sign-extended immediate, 0 = register B
//   alu_ctrl[2:0]   ALU operation
//   mem_write_en    data-memory write (MEM of sw with mem_ready)
//   mem_to_reg      1 = load data to register file
//   retired         one-cycle pulse when an instruction completes
//   illegal         sticky undecodable-instruction flag
//   state[2:0]      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   instr_count     retired-instruction counter (CNT_W bits)
//   cycle_count     cycles since reset (CNT_W bits)
module mc_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             reg_write_en,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic             mem_write_en,
  output logic             mem_to_reg,
  output logic             retired,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] ir_r;
  logic        illegal_r;

  logic        is_rtype_s;
  logic        is_addi_s;
  logic        is_lw_s;
  logic        is_sw_s;
  logic        legal_s;
  logic [2:0]  alu_dec_s;
  logic        in_exec_s;
  logic        ir_operand_unused_s;

  // Register/immediate fields are consumed by the datapath, not by this unit.
  assign ir_operand_unused_s = ^ir_r[25:6];

  // Instruction decode from the held IR (never from the live instr bus).
  always_comb begin
    is_rtype_s = 1'b0;
    is_addi_s  = 1'b0;
    is_lw_s    = 1'b0;
    is_sw_s    = 1'b0;
    alu_dec_s  = 3'b010;
    case (ir_r[31:26])
      6'b000000: begin
        case (ir_r[5:0])
          6'b100000: begin is_rtype_s = 1'b1; alu_dec_s = 3'b010; end
          6'b100010: begin is_rtype_s = 1'b1; alu_dec_s = 3'b110; end
          6'b100100: begin is_rtype_s = 1'b1; alu_dec_s = 3'b000; end
          6'b100101: begin is_rtype_s = 1'b1; alu_dec_s = 3'b001; end
          6'b101010: begin is_rtype_s = 1'b1; alu_dec_s = 3'b111; end
          default:   begin is_rtype_s = 1'b0; alu_dec_s = 3'b010; end
        endcase
      end
      6'b001000: is_addi_s = 1'b1;
      6'b100011: is_lw_s   = 1'b1;
      6'b101011: is_sw_s   = 1'b1;
      default:   is_rtype_s = 1'b0;
    endcase
  end

  assign legal_s = is_rtype_s | is_addi_s | is_lw_s | is_sw_s;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH:  state_next_s = ST_DECODE;
      ST_DECODE: begin
        if (legal_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_lw_s || is_sw_s) begin
          state_next_s = ST_MEM;
        end else begin
          state_next_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (!mem_ready) begin
          state_next_s = ST_MEM;
        end else if (is_lw_s) begin
          state_next_s = ST_WB;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_WB:   state_next_s = ST_FETCH;
      default: state_next_s = ST_FETCH;
    endcase
  end

  // State register, IR capture and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      ir_r      <= 32'h0000_0000;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_FETCH) begin
        ir_r <= instr;
      end
      if ((state_r == ST_DECODE) && !legal_s) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Decoded controls are only exposed once the instruction reaches EXEC.
  assign in_exec_s = (state_r == ST_EXEC) || (state_r == ST_MEM) || (state_r == ST_WB);

  // Control outputs; strobes are held low while reset is asserted.
  always_comb begin
    pc_en        = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    retired      = 1'b0;
    reg_dst      = in_exec_s & is_rtype_s;
    alu_src      = in_exec_s & (is_addi_s | is_lw_s | is_sw_s);
    mem_to_reg   = in_exec_s & is_lw_s;
    if (in_exec_s) begin
      alu_ctrl = alu_dec_s;
    end else begin
      alu_ctrl = 3'b010;
    end
    if (rst) begin
      pc_en        = 1'b0;
      reg_write_en = 1'b0;
      mem_write_en = 1'b0;
      retired      = 1'b0;
    end else begin
      pc_en        = (state_r == ST_FETCH);
      reg_write_en = (state_r == ST_WB);
      mem_write_en = (state_r == ST_MEM) & is_sw_s & mem_ready;
      retired      = (state_r == ST_WB) | ((state_r == ST_MEM) & is_sw_s & mem_ready);
    end
  end

  assign state   = state_r;
  assign illegal = illegal_r;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] instr_count_r;
  logic [CNT_W-1:0] cycle_count_r;

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count_r <= {CNT_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
    end else begin
      cycle_count_r <= cycle_count_r + CNT_W'(1);
      if (retired) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end
    end
  end

  assign instr_count = instr_count_r;
  assign cycle_count = cycle_count_r;
`else
  assign instr_count = {CNT_W{1'b0}};
  assign cycle_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit. Each instruction's expected cycle
// sequence is derived from its class (R-type/addi/lw/sw/illegal) and the
// number of memory stall cycles; counters are modelled with plain integers.
module tb_mc_control_unit;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          mem_ready;
  logic          pc_en, reg_write_en, reg_dst, alu_src, mem_write_en, mem_to_reg;
  logic          retired, illegal;
  logic [2:0]    alu_ctrl, state;
  logic [CW-1:0] instr_count, cycle_count;

  int   checks = 0;
  int   failures = 0;
  int   exp_cycles = 0;
  int   exp_instr = 0;
  logic exp_ill = 1'b0;

  mc_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_en(pc_en), .reg_write_en(reg_write_en), .reg_dst(reg_dst),
    .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_write_en(mem_write_en),
    .mem_to_reg(mem_to_reg), .retired(retired), .illegal(illegal),
    .state(state), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // 0=R-type 1=addi 2=lw 3=sw 4=illegal
  function automatic int classify(input logic [31:0] ins, output logic [2:0] alu);
    int k;
    alu = 3'b010;
    k = 4;
    case (ins[31:26])
      6'h00: begin
        k = 0;
        case (ins[5:0])
          6'h20: alu = 3'b010;
          6'h22: alu = 3'b110;
          6'h24: alu = 3'b000;
          6'h25: alu = 3'b001;
          6'h2A: alu = 3'b111;
          default: k = 4;
        endcase
      end
      6'h08: k = 1;
      6'h23: k = 2;
      6'h2B: k = 3;
      default: k = 4;
    endcase
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; instr = $urandom;
    tick(); tick(); #1;
    checks++;
    if ({pc_en, reg_write_en, mem_write_en, retired} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b want=0000", {pc_en, reg_write_en, mem_write_en, retired});
    end
    checks++;
    if ({state, illegal} !== 4'b0000) begin
      failures++; $display("FAIL reset_state got=%b want=0000", {state, illegal});
    end
    checks++;
    if ({instr_count, cycle_count} !== {2*CW{1'b0}}) begin
      failures++; $display("FAIL reset_counters got=%h want=0", {instr_count, cycle_count});
    end
    rst = 1'b0;
    exp_cycles = 0; exp_instr = 0; exp_ill = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int stall);
    int kind, mem_seen;
    int q[$];
    logic [2:0] alu, es, ealu;
    logic mr, pc, rwe, ex, rdst, asrc, mwe, m2r, ret;
    logic [13:0] act, expv;
    logic [CW-1:0] ec, ei;
    kind = classify(ins, alu);
    mem_seen = 0;
    q.push_back(0); q.push_back(1);
    if (kind != 4) q.push_back(2);
    if (kind == 2 || kind == 3) for (int i = 0; i <= stall; i++) q.push_back(3);
    if (kind <= 2) q.push_back(4);
    foreach (q[k]) begin
      es = 3'(q[k]);
      if (es == 3'd3) begin
        mr = (mem_seen < stall) ? 1'b0 : 1'b1;
        mem_seen++;
      end else begin
        mr = 1'($urandom % 2);
      end
      instr = (k == 0) ? ins : $urandom;
      mem_ready = mr;
      #1;
      pc   = (es == 3'd0);
      rwe  = (es == 3'd4);
      ex   = (es >= 3'd2);
      rdst = ex && kind == 0;
      asrc = ex && (kind == 1 || kind == 2 || kind == 3);
      ealu = ex ? alu : 3'b010;
      mwe  = (es == 3'd3) && kind == 3 && mr;
      m2r  = ex && kind == 2;
      ret  = rwe || mwe;
      expv = {es, pc, rwe, rdst, asrc, ealu, mwe, m2r, ret, exp_ill};
      act  = {state, pc_en, reg_write_en, reg_dst, alu_src, alu_ctrl, mem_write_en, mem_to_reg, retired, illegal};
      checks++;
      if (act !== expv) begin
        failures++;
        $display("FAIL ctrl ins=%h cyc=%0d got=%b want=%b (state,pc,rwe,rdst,asrc,alu,mwe,m2r,ret,ill)", ins, k, act, expv);
      end
`ifdef MC_CTRL_PERF_EN
      ec = exp_cycles[CW-1:0];
      ei = exp_instr[CW-1:0];
`else
      ec = '0;
      ei = '0;
`endif
      checks++;
      if ({instr_count, cycle_count} !== {ei, ec}) begin
        failures++;
        $display("FAIL counters ins=%h cyc=%0d got=%h/%h want=%h/%h", ins, k, instr_count, cycle_count, ei, ec);
      end
      if (ret) exp_instr++;
      if (es == 3'd1 && kind == 4) exp_ill = 1'b1;
      exp_cycles++;
      tick();
    end
  endtask

  task automatic test_addi_add();
    logic [CW-1:0] ei;
    run_instr(32'h2001_0005, 0);
    run_instr(32'h0022_1820, 0);
    #1;
`ifdef MC_CTRL_PERF_EN
    ei = CW'(2);
`else
    ei = '0;
`endif
    checks++;
    if (instr_count !== ei) begin
      failures++; $display("FAIL addi_add_count got=%0d want=%0d", instr_count, ei);
    end
  endtask

  task automatic test_lw_stall();
    run_instr(32'h8C22_0004, 3);
  endtask

  task automatic test_sw();
    run_instr(32'hAC22_0008, 0);
  endtask

  task automatic test_illegal();
    run_instr(32'hFC00_0000, 0);
    run_instr(32'h0000_0001, 0);
    run_instr(32'h0022_1820, 0);
  endtask

  task automatic test_reset_mid_mem();
    for (int i = 0; i < 3; i++) begin
      instr = (i == 0) ? 32'h8C22_0004 : $urandom;
      mem_ready = 1'($urandom % 2);
      #1; tick();
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (state !== 3'd3) begin
      failures++; $display("FAIL mid_mem_reach got=%0d want=3", state);
    end
    tick();
    rst = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if ({pc_en, reg_write_en, mem_write_en, retired} !== 4'b0000) begin
      failures++; $display("FAIL mid_mem_rst_strobes got=%b want=0000", {pc_en, reg_write_en, mem_write_en, retired});
    end
    tick();
    rst = 1'b0; #1;
    checks++;
    if ({state, reg_write_en} !== 4'b0000) begin
      failures++; $display("FAIL mid_mem_after got=%b want=0000", {state, reg_write_en});
    end
    checks++;
    if (instr_count !== {CW{1'b0}}) begin
      failures++; $display("FAIL mid_mem_count got=%0d want=0", instr_count);
    end
    exp_cycles = 0; exp_instr = 0; exp_ill = 1'b0;
  endtask

  task automatic test_wrap();
    logic [CW-1:0] ei;
    test_reset();
    for (int i = 0; i < 4; i++) run_instr(32'h2001_0005, 0);
    #1;
`ifdef MC_CTRL_PERF_EN
    ei = CW'(4);
`else
    ei = '0;
`endif
    checks++;
    if ({cycle_count, instr_count} !== {{CW{1'b0}}, ei}) begin
      failures++; $display("FAIL wrap got=%0d/%0d want=0/%0d", cycle_count, instr_count, ei);
    end
  endtask

  task automatic test_random();
    logic [5:0] functs [5];
    logic [31:0] r, ins;
    logic [5:0] f;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      case ($urandom_range(0, 5))
        0: ins = {6'h00, r[25:6], functs[$urandom_range(0, 4)]};
        1: ins = {6'h08, r[25:0]};
        2: ins = {6'h23, r[25:0]};
        3: ins = {6'h2B, r[25:0]};
        4: begin
          f = r[5:0];
          while (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) f = f + 6'd1;
          ins = {6'h00, r[25:6], f};
        end
        default: begin
          f = r[31:26];
          while (f inside {6'h00, 6'h08, 6'h23, 6'h2B}) f = f + 6'd1;
          ins = {f, r[25:0]};
        end
      endcase
      run_instr(ins, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_lw_stall();
    test_sw();
    test_illegal();
    test_reset_mid_mem();
    test_addi_add();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
